buzz_scheduler: RTL and testbench
=================================

Name: buzz_scheduler

Overview:
- Shares the single piezo buzzer between NREQ independent requesters, e.g. the alarm, key-click and timer-done sources.
- Each requester posts a job of 0..7 beeps. Jobs are served one at a time in fixed priority: index 0 is highest.
- The block generates the on/off beep timing itself and drives the buzzer pin directly.
- Each served job returns a one-cycle done pulse to its requester.
- Runs on the 1 ms system tick clock.

Parameters:
NREQ, 3, number of requesters (2..8)
ON_MS, 200, beep-on duration in clkms cycles (>=1)
OFF_MS, 200, silence between beeps of one job, in clkms cycles (>=1)
GAP_MS, 500, enforced silence after a job before the next grant, in clkms cycles (>=1)
CNTW, 10, timer width; must hold max(ON_MS,OFF_MS,GAP_MS)-1

Ports:
clkms  in  1  1 ms system clock
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester job request, sampled every edge (pulse or level)
beeps  in  3*NREQ  beep count for requester i at bits [3i+2:3i], sampled at grant
cancel  in  1  abort current job and flush all pending requests
mute  in  1  forces buzz low; timing and handshakes unaffected
grant  out  NREQ  one-hot, requester currently being served
done  out  NREQ  one-hot one-cycle pulse at job completion
busy  out  1  high when state != IDLE
buzz  out  1  buzzer drive, registered

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; pending, timer and beep counter cleared.
  - grant=0, done=0, busy=0, buzz=0.
  - Applies immediately, including mid-job.
- pending[i]:
  - Set at any edge where req[i]=1.
  - Cleared at the edge where i is granted, unless req[i]=1 on that same edge; set wins.
  - Repeated req while pending merges into one job.
  - req[i] during i's own service sets pending, so i is served again after GAP.
- States:
  - IDLE -> ON: any pending.
    - Select the lowest pending index i.
    - grant=onehot(i); beep counter <= beeps[i]; timer <= ON_MS-1; buzz <= 1.
    - If beeps[i]==0: grant, done[i] and GAP entry happen on the same edge, with no buzz. That is a done pulse one cycle after grant-eligible.
  - ON, timer>0: decrement timer.
  - ON, timer==0, counter>1: counter--, timer <= OFF_MS-1, buzz <= 0, go OFF.
  - ON, timer==0, counter==1: buzz <= 0, grant <= 0, done[i] <= 1 for one cycle, timer <= GAP_MS-1, go GAP.
  - OFF, timer==0: timer <= ON_MS-1, buzz <= 1, go ON.
  - GAP, timer==0: go IDLE. Arbitration happens on the next edge.
- Timing:
  - req at edge T gives pending after T, grant and buzz=1 after T+1.
  - A job of n beeps keeps buzz high/low for exactly n*ON_MS + (n-1)*OFF_MS cycles from the grant edge, starting high.
  - Next grant is no earlier than GAP_MS+1 cycles after done.
- Priority:
  - Evaluated only in IDLE. No preemption; a higher request arriving mid-job waits.
- cancel=1 at an edge, from any state:
  - go IDLE; pending cleared, including a req on the same edge.
  - grant=0, buzz=0, no done pulse.
  - No GAP is applied.
- mute: buzz output forced 0 combinationally over the registered value; everything else is unchanged.
- Outputs:
  - done is never asserted together with grant of the same index on the same cycle, except in the beeps==0 case.
  - At most one done bit is high.

Test Plan:
Use ON_MS=4, OFF_MS=3, GAP_MS=5, NREQ=3.
1. req[0] pulse at edge 0, beeps0=2 -> grant[0]=1 and buzz=1 after edge 1; buzz high edges 1-4, low 5-7, high 8-11; done[0] pulse after edge 12 with grant=0 at the same edge; busy falls after edge 17.
2. req[2] and req[0] both pulsed at edge 0, beeps=1 each -> grant[0] after edge 1, done[0] after edge 5; grant[2] after edge 11, done[2] after edge 15.
3. Re-request and merging: req[1] repeated every cycle for 3 edges, then again mid-job -> exactly two jobs of requester 1 served, separated by the GAP.
4. beeps1=0, req[1] at edge 0 -> after edge 1: grant[1] and done[1] for one cycle; buzz stays 0; busy for 5 cycles.
5. Cancel mid-job: cancel at edge 3 of a 3-beep job with req[2] pending -> buzz=0, grant=0, busy=0 after edge 3; no done; req[2] is not served afterwards.
6. Reset and mute:
   - rst_n low mid-ON -> buzz, grant, busy drop immediately without a clock; after release with no req, the block stays IDLE.
   - mute=1 during a job -> buzz=0 throughout, but done timing is identical to scenario 1.

Source files
------------

// File: rtl/buzz_scheduler.sv
// rtl/buzz_scheduler.sv - fixed-priority beep job scheduler driving a single piezo buzzer
// Serves one requester job at a time: n beeps of ON/OFF timing followed by a silent gap.
module buzz_scheduler #(
  parameter int NREQ   = 3,
  parameter int ON_MS  = 200,
  parameter int OFF_MS = 200,
  parameter int GAP_MS = 500,
  parameter int CNTW   = 10
) (
  input  logic              clkms,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] beeps,
  input  logic              cancel,
  input  logic              mute,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              buzz
);

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  localparam logic [CNTW-1:0] ON_T  = CNTW'(ON_MS - 1);
  localparam logic [CNTW-1:0] OFF_T = CNTW'(OFF_MS - 1);
  localparam logic [CNTW-1:0] GAP_T = CNTW'(GAP_MS - 1);

  state_t          state;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] sel_oh;
  logic [2:0]      sel_beeps;
  logic [2:0]      cnt;
  logic [CNTW-1:0] timer;
  logic            buzz_q;

  // Lowest pending index wins; scanning downward leaves the lowest one selected.
  always_comb begin
    sel_oh    = '0;
    sel_beeps = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_beeps = beeps[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clkms or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      grant   <= '0;
      done    <= '0;
      cnt     <= '0;
      timer   <= '0;
      buzz_q  <= 1'b0;
    end else begin
      done <= '0;
      if (cancel) begin
        state   <= IDLE;
        pending <= '0;
        grant   <= '0;
        cnt     <= '0;
        timer   <= '0;
        buzz_q  <= 1'b0;
      end else begin
        pending <= pending | req;
        case (state)
          IDLE: begin
            if (|pending) begin
              // A same-edge request re-arms the bit being granted.
              pending <= (pending & ~sel_oh) | req;
              grant   <= sel_oh;
              cnt     <= sel_beeps;
              if (sel_beeps == 3'd0) begin
                done  <= sel_oh;
                timer <= GAP_T;
                state <= GAP;
              end else begin
                timer  <= ON_T;
                buzz_q <= 1'b1;
                state  <= ON;
              end
            end
          end
          ON: begin
            if (timer != '0) begin
              timer <= timer - 1'b1;
            end else if (cnt > 3'd1) begin
              cnt    <= cnt - 3'd1;
              timer  <= OFF_T;
              buzz_q <= 1'b0;
              state  <= OFF;
            end else begin
              buzz_q <= 1'b0;
              grant  <= '0;
              done   <= grant;
              timer  <= GAP_T;
              state  <= GAP;
            end
          end
          OFF: begin
            if (timer != '0) begin
              timer <= timer - 1'b1;
            end else begin
              timer  <= ON_T;
              buzz_q <= 1'b1;
              state  <= ON;
            end
          end
          GAP: begin
            grant <= '0;
            if (timer != '0) timer <= timer - 1'b1;
            else             state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);
  assign buzz = buzz_q & ~mute;

endmodule

// File: tb/tb_buzz_scheduler.sv
// tb/tb_buzz_scheduler.sv - scoreboard bench for buzz_scheduler with ON=4, OFF=3, GAP=5
// Stimulus pushes expected output changes; a negedge monitor pops and compares them.
module tb_buzz_scheduler;

  logic       clkms;
  logic       rst_n;
  logic [2:0] req;
  logic [8:0] beeps;
  logic       cancel;
  logic       mute;
  logic [2:0] grant;
  logic [2:0] done;
  logic       busy;
  logic       buzz;

  buzz_scheduler #(
    .NREQ(3), .ON_MS(4), .OFF_MS(3), .GAP_MS(5), .CNTW(10)
  ) dut (
    .clkms (clkms),
    .rst_n (rst_n),
    .req   (req),
    .beeps (beeps),
    .cancel(cancel),
    .mute  (mute),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .buzz  (buzz)
  );

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } ev_t;

  ev_t        exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         base = 0;
  string      tag = "reset";
  logic [7:0] prev = 8'h00;

  initial clkms = 1'b0;
  always #5 clkms = ~clkms;

  always @(posedge clkms) cyc <= cyc + 1;

  // Expected value packing: {grant[2:0], done[2:0], buzz, busy}
  task automatic push(input int k, input logic [2:0] g, input logic [2:0] d,
                      input logic b, input logic bs);
    ev_t e;
    e.cyc = base + k;
    e.v   = {g, d, b, bs};
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s/%s: got %b, required %b", tag, name, act, expv);
    end
  endtask

  // Start a scenario at a negedge; the next posedge is edge 0.
  task automatic start(input string name);
    tag  = name;
    base = cyc + 1;
  endtask

  always @(negedge clkms) begin
    logic [7:0] cur;
    ev_t        e;
    cur = {grant, done, buzz, busy};
    if (cur !== prev) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s/unexpected: cyc %0d outputs %b, required no change from %b",
                 tag, cyc, cur, prev);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.v !== cur) begin
          miscompares++;
          $display("FAIL %s/event: cyc %0d outputs %b, required cyc %0d outputs %b",
                   tag, cyc, cur, e.cyc, e.v);
        end
      end
      prev = cur;
    end
  end

  initial begin
    rst_n  = 1'b1;
    req    = '0;
    beeps  = '0;
    cancel = 1'b0;
    mute   = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clkms);
    chk("reset_state", {grant, done, buzz, busy}, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clkms);

    // 1: two-beep job on requester 0
    start("s1_two_beeps");
    beeps = 9'o002; req = 3'b001;
    push(1,  3'b001, 3'b000, 1, 1);
    push(5,  3'b001, 3'b000, 0, 1);
    push(8,  3'b001, 3'b000, 1, 1);
    push(12, 3'b000, 3'b001, 0, 1);
    push(13, 3'b000, 3'b000, 0, 1);
    push(17, 3'b000, 3'b000, 0, 0);
    @(negedge clkms); req = '0;
    repeat (20) @(negedge clkms);

    // 2: simultaneous requests, priority and gap
    start("s2_priority");
    beeps = 9'o111; req = 3'b101;
    push(1,  3'b001, 3'b000, 1, 1);
    push(5,  3'b000, 3'b001, 0, 1);
    push(6,  3'b000, 3'b000, 0, 1);
    push(10, 3'b000, 3'b000, 0, 0);
    push(11, 3'b100, 3'b000, 1, 1);
    push(15, 3'b000, 3'b100, 0, 1);
    push(16, 3'b000, 3'b000, 0, 1);
    push(20, 3'b000, 3'b000, 0, 0);
    @(negedge clkms); req = '0;
    repeat (23) @(negedge clkms);

    // 3: merged repeats of req[1] while 0 is served, then a re-request during 1's service
    start("s3_merge");
    beeps = 9'o111; req = 3'b001;
    push(1,  3'b001, 3'b000, 1, 1);
    push(5,  3'b000, 3'b001, 0, 1);
    push(6,  3'b000, 3'b000, 0, 1);
    push(10, 3'b000, 3'b000, 0, 0);
    push(11, 3'b010, 3'b000, 1, 1);
    push(15, 3'b000, 3'b010, 0, 1);
    push(16, 3'b000, 3'b000, 0, 1);
    push(20, 3'b000, 3'b000, 0, 0);
    push(21, 3'b010, 3'b000, 1, 1);
    push(25, 3'b000, 3'b010, 0, 1);
    push(26, 3'b000, 3'b000, 0, 1);
    push(30, 3'b000, 3'b000, 0, 0);
    @(negedge clkms); req = 3'b010;
    repeat (3) @(negedge clkms); req = '0;
    repeat (9) @(negedge clkms); req = 3'b010;
    @(negedge clkms); req = '0;
    repeat (27) @(negedge clkms);

    // 4: zero-beep job
    start("s4_zero_beeps");
    beeps = 9'o000; req = 3'b010;
    push(1, 3'b010, 3'b010, 0, 1);
    push(2, 3'b000, 3'b000, 0, 1);
    push(6, 3'b000, 3'b000, 0, 0);
    @(negedge clkms); req = '0;
    repeat (9) @(negedge clkms);

    // 5: cancel mid-job flushes pending req[2]
    start("s5_cancel");
    beeps = 9'o113; req = 3'b001;
    push(1, 3'b001, 3'b000, 1, 1);
    push(3, 3'b000, 3'b000, 0, 0);
    @(negedge clkms); req = 3'b100;
    @(negedge clkms); req = '0;
    @(negedge clkms); cancel = 1'b1;
    @(negedge clkms); cancel = 1'b0;
    repeat (20) @(negedge clkms);

    // 6a: asynchronous reset during ON
    start("s6_reset");
    beeps = 9'o002; req = 3'b001;
    push(1, 3'b001, 3'b000, 1, 1);
    push(3, 3'b000, 3'b000, 0, 0);
    @(negedge clkms); req = '0;
    repeat (2) @(negedge clkms);
    #1 rst_n = 1'b0;
    #1;
    chk("async_buzz",  {7'd0, buzz},  8'h00);
    chk("async_grant", {5'd0, grant}, 8'h00);
    chk("async_busy",  {7'd0, busy},  8'h00);
    repeat (2) @(negedge clkms); rst_n = 1'b1;
    repeat (10) @(negedge clkms);
    chk("idle_after_reset", {grant, done, buzz, busy}, 8'h00);

    // 6b: muted job keeps scenario 1 handshake timing
    start("s6_mute");
    mute = 1'b1; beeps = 9'o002; req = 3'b001;
    push(1,  3'b001, 3'b000, 0, 1);
    push(12, 3'b000, 3'b001, 0, 1);
    push(13, 3'b000, 3'b000, 0, 1);
    push(17, 3'b000, 3'b000, 0, 0);
    @(negedge clkms); req = '0;
    repeat (20) @(negedge clkms);
    mute = 1'b0;
    repeat (2) @(negedge clkms);

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event: got no change by end, required cyc %0d outputs %b",
               e.cyc, e.v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
